// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        RUN,
        ERR
    } state_e;

    localparam logic [7:0]  CSUM_SEED      = 8'h00;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned SHIFT_W        = 8 * (BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream. The first byte of a
// word lands in bits [7:0]. The completed word is registered together with a
// one-cycle word_valid pulse in the cycle after the fourth byte is accepted.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        lane_last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [LANE_W-1:0]  lane_q;
    logic [SHIFT_W-1:0] shreg_q;
    logic [31:0]        word_q;
    logic               valid_q;

    // Current byte is the last lane of a word
    always_comb begin
        lane_last = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    end

    // Lane counter, shift register and registered word output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                lane_q  <= '0;
                shreg_q <= '0;
            end else if (byte_en) begin
                if (lane_last) begin
                    word_q  <= {byte_in, shreg_q};
                    valid_q <= 1'b1;
                    lane_q  <= '0;
                end else begin
                    // Shift right so earlier bytes end up in the low lanes
                    shreg_q <= {byte_in, shreg_q[SHIFT_W-1:8]};
                    lane_q  <= lane_q + LANE_W'(1);
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader. Parses LEN_LO, LEN_HI, 4*N payload bytes
// and an XOR checksum byte, writes each assembled word to consecutive
// instruction-memory addresses, and releases the core only after the
// checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic        xfer;
    logic        pk_en;
    logic        pk_clear;
    logic        pk_last;
    logic [31:0] pk_word;
    logic        pk_valid;

    // Byte handshake and status decoded straight from the state register
    always_comb begin
        byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CSUM);
        xfer       = byte_valid && byte_ready;
        pk_en      = xfer && (state_q == DATA);
        core_run   = (state_q == RUN);
        done       = (state_q == RUN);
        error      = (state_q == ERR);
    end

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_en    (pk_en),
        .byte_in    (byte_data),
        .lane_last  (pk_last),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    // Next-state logic: frame parsing, word counting, running checksum
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        csum_d   = csum_q;
        count_d  = count_q;
        addr_d   = addr_q;
        pk_clear = 1'b0;

        unique case (state_q)
            LEN_LO: begin
                if (xfer) begin
                    len_d   = {8'h00, byte_data};
                    csum_d  = csum_q ^ byte_data;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d  = {byte_data, len_q[7:0]};
                    csum_d = csum_q ^ byte_data;
                    if (32'(len_d) > DEPTH) begin
                        state_d = ERR;
                    end else if (len_d == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ byte_data;
                    if (pk_last) begin
                        // Address latched alongside the packer's word register
                        addr_d  = count_q[ADDR_W-1:0];
                        count_d = count_q + 16'd1;
                        if (count_q == len_q - 16'd1) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = (byte_data == csum_q) ? RUN : ERR;
                end
            end
            RUN, ERR: begin
                if (restart) begin
                    state_d  = LEN_LO;
                    len_d    = 16'd0;
                    csum_d   = CSUM_SEED;
                    count_d  = 16'd0;
                    pk_clear = 1'b1;
                end
            end
            default: begin
                state_d = LEN_LO;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LEN_LO;
            len_q   <= 16'd0;
            csum_q  <= CSUM_SEED;
            count_q <= 16'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            count_q <= count_d;
            addr_q  <= addr_d;
        end
    end

    assign imem_we    = pk_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = pk_word;
    assign word_count = count_q;

endmodule
